mips32i_mem_arbiter: RTL
========================

Name: mips32i_mem_arbiter

Overview:
- Shares one memory port between the CPU's instruction-fetch requester and data (load/store) requester.
- Sits between the mips32i core's fetch/data interfaces and a unified, variable-latency memory.
- Each transaction is a req/ack handshake. Ties between requesters are resolved round-robin.
- A watchdog aborts hung memory transactions and raises a sticky error.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- TIMEOUT, 255, maximum BUSY cycles waiting for m_ack before abort (1..65535; 16-bit counter).
- ERR_DATA, 32'hDEADBEEF, read data returned on an aborted transaction.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- i_req  input  1  instruction fetch request; held until i_ack.
- i_addr  input  ADDR_W  fetch address; stable while i_req is high.
- i_rdata  output  DATA_W  fetched word; valid while i_ack is high.
- i_ack  output  1  one-cycle completion pulse for fetch.
- d_req  input  1  data request; held until d_ack.
- d_we  input  1  1 = store, 0 = load.
- d_size  input  2  access size, opcode[1:0] encoding (00 byte, 01 half, 11 word).
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_rdata  output  DATA_W  load data; valid while d_ack is high.
- d_ack  output  1  one-cycle completion pulse for data.
- m_req  output  1  memory request; held until m_ack or timeout.
- m_we  output  1  memory write enable.
- m_size  output  2  memory access size.
- m_addr  output  ADDR_W  memory address.
- m_wdata  output  DATA_W  memory write data.
- m_rdata  input  DATA_W  memory read data; valid with m_ack.
- m_ack  input  1  memory completion; single-cycle pulse.
- cpu_stall  output  1  combinational: (i_req & ~i_ack) | (d_req & ~d_ack).
- bus_err  output  1  sticky timeout flag; cleared only by rst.

Behaviour:
- Reset (rst=1 at a rising edge, any state, including mid-transaction):
  - state=IDLE; last_grant=DATA, so the instruction side wins the first tie.
  - m_req=0, m_we=0, m_size=0, m_addr=0, m_wdata=0.
  - i_ack=0, d_ack=0, i_rdata=0, d_rdata=0.
  - timeout counter=0, bus_err=0.
  - An in-flight memory transaction is abandoned. Any m_ack arriving later while in IDLE is ignored.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - Only i_req: go to BUSY_I.
  - Only d_req: go to BUSY_D.
  - Both: grant the side not equal to last_grant.
  - On grant, register address/we/size/wdata into the m_* outputs, set m_req=1, update last_grant. m_req is high the cycle after the request is sampled.
  - Fetch grants drive m_we=0, m_size=2'b11, m_wdata=0.
- BUSY_x:
  - Hold all m_* outputs stable; increment the counter each cycle.
  - m_ack=1: capture m_rdata into x_rdata, set x_ack=1, m_req=0, go to RESP.
  - Counter reaches TIMEOUT without m_ack: x_rdata=ERR_DATA, x_ack=1, m_req=0, bus_err=1, go to RESP.
  - m_ack in the same cycle the counter hits TIMEOUT: m_ack wins; no error.
- RESP:
  - Exactly one cycle. x_ack is high here; both acks drop at the end.
  - Requests are ignored in RESP, so no double grant of a request still held high.
  - Next state is always IDLE; the counter clears.
  - Stores also return ack; rdata is don't-care but must hold the captured m_rdata value.
- Latency: request sampled at edge N gives m_req at N+1. m_ack at cycle M gives x_ack at M+1. Minimum request-to-ack is 3 cycles; a back-to-back grant is possible from the cycle after RESP.
- Requesters must deassert req or present a new request the cycle after ack. Inputs changing while in BUSY have no effect.
- Only one m_req is outstanding at a time; i_ack and d_ack are never high together.
- x_rdata holds its value until the next completion for that side.

Test Plan:
- Single fetch:
  - Stimulus: i_addr=0x0000_0040, m_ack returned 2 cycles after m_req, m_rdata=0x2008_0005.
  - Required: i_ack pulse exactly 1 cycle with i_rdata=0x2008_0005; m_size=11, m_we=0; d_ack stays 0.
- Simultaneous requests after reset:
  - Stimulus: i_req and d_req both high, with d_we=1, d_addr=0x100, d_wdata=0xCAFEF00D, d_size=11.
  - Required: fetch is served first; then the store appears on m_* with m_we=1 and m_wdata=0xCAFEF00D.
  - Further tie pairs alternate grants I, D, I, D.
- Held request across RESP:
  - Stimulus: keep i_req high 1 cycle past i_ack.
  - Required: exactly one memory transaction, no second grant from RESP; new grant only from IDLE.
- Timeout:
  - Stimulus: TIMEOUT=4, d_req load, never assert m_ack.
  - Required: after 4 BUSY cycles, d_ack with d_rdata=0xDEADBEEF; bus_err=1 and stays 1; the next request completes normally.
- Reset mid-transaction:
  - Stimulus: assert rst while in BUSY_D, then pulse m_ack after rst is released.
  - Required: m_req=0 and all outputs at reset values the cycle after rst; the stray m_ack produces no ack.
- cpu_stall:
  - Stimulus: d_req held with a 5-cycle memory latency.
  - Required: cpu_stall high from d_req rise until the d_ack cycle; low in the d_ack cycle.

Source files
------------

// File: rtl/mips32i_mem_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data
// load/store with round-robin tie breaking and a watchdog on hung transactions.
module mips32i_mem_arbiter #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_req,
    output logic              m_we,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              cpu_stall,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    state_t            state_q;
    logic              last_d_q;
    logic [15:0]       cnt_q;
    logic [15:0]       cnt_d;
    logic              m_req_q;
    logic              m_we_q;
    logic [1:0]        m_size_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic              i_ack_q;
    logic              d_ack_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              bus_err_q;
    logic              grant_i_s;
    logic              timeout_s;

    // Fetch wins when alone, or on a tie when data was served last.
    assign grant_i_s = i_req & (~d_req | last_d_q);
    assign cnt_d     = cnt_q + 16'd1;
    assign timeout_s = (cnt_d == TIMEOUT_C);

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_d_q  <= 1'b1;
            cnt_q     <= 16'd0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_size_q  <= 2'b00;
            m_addr_q  <= {ADDR_W{1'b0}};
            m_wdata_q <= {DATA_W{1'b0}};
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= {DATA_W{1'b0}};
            d_rdata_q <= {DATA_W{1'b0}};
            bus_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_i_s) begin
                        state_q   <= ST_BUSY_I;
                        last_d_q  <= 1'b0;
                        m_req_q   <= 1'b1;
                        m_we_q    <= 1'b0;
                        m_size_q  <= 2'b11;
                        m_addr_q  <= i_addr;
                        m_wdata_q <= {DATA_W{1'b0}};
                    end else if (d_req) begin
                        state_q   <= ST_BUSY_D;
                        last_d_q  <= 1'b1;
                        m_req_q   <= 1'b1;
                        m_we_q    <= d_we;
                        m_size_q  <= d_size;
                        m_addr_q  <= d_addr;
                        m_wdata_q <= d_wdata;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    // A real m_ack in the watchdog's final cycle still counts as success.
                    if (m_ack || timeout_s) begin
                        state_q   <= ST_RESP;
                        m_req_q   <= 1'b0;
                        bus_err_q <= bus_err_q | ~m_ack;
                        if (state_q == ST_BUSY_I) begin
                            i_ack_q   <= 1'b1;
                            i_rdata_q <= m_ack ? m_rdata : ERR_DATA;
                        end else begin
                            d_ack_q   <= 1'b1;
                            d_rdata_q <= m_ack ? m_rdata : ERR_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 16'd0;
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_req     = m_req_q;
    assign m_we      = m_we_q;
    assign m_size    = m_size_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign bus_err   = bus_err_q;
    assign cpu_stall = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);

endmodule
